// File: rtl/guess_checker.sv
`default_nettype none
// ============================================================================
//  Module      : guess_checker
//  Description : Five-letter word-guessing game. A single shared comparator
//                scans the secret word one character per cycle per guess.
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_checker #(
    parameter int WORD_CHARS = 5,
    parameter int MAX_MISSES = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8*WORD_CHARS-1:0]   word,
    input  logic                      word_valid,
    input  logic [7:0]                letter,
    input  logic                      letter_valid,
    output logic                      ready,
    output logic [7:0]                letter_out,
    output logic [WORD_CHARS-1:0]     indexCorrect,
    output logic [2:0]                correct,
    output logic [2:0]                incorrect,
    output logic                      mistake,
    output logic                      gameEnd,
    output logic                      win
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_SCAN = 3'd2;
    localparam logic [2:0] S_EVAL = 3'd3;
    localparam logic [2:0] S_WIN  = 3'd4;
    localparam logic [2:0] S_LOSE = 3'd5;

    localparam logic [7:0]            c_ASCII_A   = 8'h41;
    localparam logic [7:0]            c_ASCII_Z   = 8'h5A;
    localparam logic [2:0]            c_LAST_IDX  = 3'(WORD_CHARS - 1);
    localparam logic [2:0]            c_MAX_MISS  = 3'(MAX_MISSES);
    localparam logic [WORD_CHARS-1:0] c_ALL_HIT   = '1;
    localparam logic [WORD_CHARS-1:0] c_FIRST_BIT = WORD_CHARS'(1) << (WORD_CHARS - 1);

    logic [2:0]                r_state;
    logic [2:0]                w_next_state;
    logic [8*WORD_CHARS-1:0]   r_word;
    logic [2:0]                r_idx;
    logic [WORD_CHARS-1:0]     r_hits;
    logic [7:0]                r_letter_out;
    logic [WORD_CHARS-1:0]     r_index_correct;
    logic [2:0]                r_correct;
    logic [2:0]                r_incorrect;
    logic                      r_mistake;

    logic                      w_letter_ok;
    logic                      w_accept;
    logic [7:0]                w_char;
    logic                      w_match;
    logic [WORD_CHARS-1:0]     w_sel;
    logic [WORD_CHARS-1:0]     w_mask_next;
    logic [2:0]                w_incorrect_next;
    logic                      w_miss;

    function automatic logic [2:0] popcount(input logic [WORD_CHARS-1:0] m);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < WORD_CHARS; i++) begin
            cnt = cnt + {2'b00, m[i]};
        end
        return cnt;
    endfunction

    assign w_letter_ok = (letter >= c_ASCII_A) && (letter <= c_ASCII_Z);
    assign w_accept    = (r_state == S_PLAY) && letter_valid && w_letter_ok;

    // Character idx counts from the most significant byte of the word.
    always_comb begin
        w_char = r_word[7:0];
        for (int i = 0; i < WORD_CHARS; i++) begin
            if (r_idx == 3'(i)) begin
                w_char = r_word[8*(WORD_CHARS-1-i) +: 8];
            end
        end
    end

    assign w_match = (w_char == r_letter_out);
    assign w_sel   = c_FIRST_BIT >> r_idx;

    // Values committed on the evaluation edge; also steer the post-EVAL state.
    assign w_miss           = (r_hits == '0);
    assign w_mask_next      = r_index_correct | r_hits;
    assign w_incorrect_next = (w_miss && (r_incorrect != c_MAX_MISS)) ?
                              (r_incorrect + 3'd1) : r_incorrect;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; a new word overrides anything in flight
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (word_valid) begin
            w_next_state = S_PLAY;
        end else begin
            case (r_state)
                S_IDLE: w_next_state = S_IDLE;
                S_PLAY: begin
                    if (w_accept) begin
                        w_next_state = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_idx == c_LAST_IDX) begin
                        w_next_state = S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_mask_next == c_ALL_HIT) begin
                        w_next_state = S_WIN;
                    end else if (w_incorrect_next == c_MAX_MISS) begin
                        w_next_state = S_LOSE;
                    end else begin
                        w_next_state = S_PLAY;
                    end
                end
                S_WIN:   w_next_state = S_WIN;
                S_LOSE:  w_next_state = S_LOSE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready   = 1'b0;
        gameEnd = 1'b0;
        win     = 1'b0;
        case (r_state)
            S_PLAY: ready = 1'b1;
            S_WIN: begin
                gameEnd = 1'b1;
                win     = 1'b1;
            end
            S_LOSE:  gameEnd = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word          <= '0;
            r_idx           <= 3'd0;
            r_hits          <= '0;
            r_letter_out    <= 8'd0;
            r_index_correct <= '0;
            r_correct       <= 3'd0;
            r_incorrect     <= 3'd0;
            r_mistake       <= 1'b0;
        end else if (word_valid) begin
            r_word          <= word;
            r_idx           <= 3'd0;
            r_hits          <= '0;
            r_letter_out    <= 8'd0;
            r_index_correct <= '0;
            r_correct       <= 3'd0;
            r_incorrect     <= 3'd0;
            r_mistake       <= 1'b0;
        end else begin
            r_mistake <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    if (w_accept) begin
                        r_letter_out <= letter;
                        r_hits       <= '0;
                        r_idx        <= 3'd0;
                    end
                end
                S_SCAN: begin
                    r_hits <= r_hits | (w_match ? w_sel : '0);
                    r_idx  <= r_idx + 3'd1;
                end
                S_EVAL: begin
                    // A repeat of an already revealed letter leaves everything unchanged.
                    r_index_correct <= w_mask_next;
                    r_correct       <= popcount(w_mask_next);
                    r_incorrect     <= w_incorrect_next;
                    r_mistake       <= w_miss;
                end
                default: ;
            endcase
        end
    end

    assign letter_out   = r_letter_out;
    assign indexCorrect = r_index_correct;
    assign correct      = r_correct;
    assign incorrect    = r_incorrect;
    assign mistake      = r_mistake;

endmodule
`default_nettype wire

// File: tb/tb_guess_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_guess_checker
//  Description : Self-checking bench for guess_checker against a game-level
//                reference model (directed scenarios plus random games).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_checker;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic [39:0] word;
    logic        word_valid;
    logic [7:0]  letter;
    logic        letter_valid;
    logic        ready;
    logic [7:0]  letter_out;
    logic [4:0]  indexCorrect;
    logic [2:0]  correct;
    logic [2:0]  incorrect;
    logic        mistake;
    logic        gameEnd;
    logic        win;

    int errors = 0;
    int checks = 0;

    always #5 tb_clk = ~tb_clk;

    guess_checker dut (
        .clk          (tb_clk),
        .rst          (rst),
        .word         (word),
        .word_valid   (word_valid),
        .letter       (letter),
        .letter_valid (letter_valid),
        .ready        (ready),
        .letter_out   (letter_out),
        .indexCorrect (indexCorrect),
        .correct      (correct),
        .incorrect    (incorrect),
        .mistake      (mistake),
        .gameEnd      (gameEnd),
        .win          (win)
    );

    // Game-level reference model
    logic [7:0] m_word [5];
    logic [4:0] m_mask;
    int         m_inc;
    logic [7:0] m_letter;
    bit         m_mistake;
    bit         m_started;
    bit         m_busy;

    function automatic bit m_won();
        return m_mask == 5'b11111;
    endfunction

    function automatic bit m_over();
        return m_won() || (m_inc == 6);
    endfunction

    function automatic void m_clear();
        m_mask    = '0;
        m_inc     = 0;
        m_letter  = 8'd0;
        m_mistake = 1'b0;
        m_busy    = 1'b0;
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"},        {7'd0, ready},        {7'd0, m_started && !m_over() && !m_busy});
        chk({tag, ".letter_out"},   letter_out,           m_letter);
        chk({tag, ".indexCorrect"}, {3'd0, indexCorrect}, {3'd0, m_mask});
        chk({tag, ".correct"},      {5'd0, correct},      8'($countones(m_mask)));
        chk({tag, ".incorrect"},    {5'd0, incorrect},    8'(m_inc));
        chk({tag, ".mistake"},      {7'd0, mistake},      {7'd0, m_mistake});
        chk({tag, ".gameEnd"},      {7'd0, gameEnd},      {7'd0, m_started && m_over()});
        chk({tag, ".win"},          {7'd0, win},          {7'd0, m_started && m_won()});
    endtask

    task automatic new_word(input logic [39:0] w);
        word       = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        for (int i = 0; i < 5; i++) m_word[i] = w[39-8*i -: 8];
        m_clear();
        m_started = 1'b1;
        check_all("new_word");
    endtask

    task automatic do_guess(input logic [7:0] l);
        bit         acc;
        logic [4:0] hits;
        acc = m_started && !m_over() && !m_busy && (l >= 8'h41) && (l <= 8'h5A);
        letter       = l;
        letter_valid = 1'b1;
        tick();
        letter_valid = 1'b0;
        if (acc) begin
            m_letter = l;
            m_busy   = 1'b1;
            check_all("accept");
            repeat (6) tick();
            hits = '0;
            for (int i = 0; i < 5; i++) if (m_word[i] == l) hits[4-i] = 1'b1;
            if (hits == '0) begin
                m_mistake = 1'b1;
                if (m_inc < 6) m_inc++;
            end
            m_mask = m_mask | hits;
            m_busy = 1'b0;
            check_all("eval");
            tick();
            m_mistake = 1'b0;
            check_all("post");
        end else begin
            check_all("drop");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] w;
        int          r;
        logic [7:0]  l;

        rst          = 1'b1;
        word         = '0;
        word_valid   = 1'b0;
        letter       = 8'd0;
        letter_valid = 1'b0;
        m_started    = 1'b0;
        m_clear();
        for (int i = 0; i < 5; i++) m_word[i] = 8'd0;
        tick();
        tick();
        check_all("reset");

        // rst dominates a same-cycle word_valid
        word       = 40'h4D4F4F5245;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        check_all("rst_over_word");
        rst = 1'b0;

        // IDLE ignores guesses
        do_guess(8'h4D);

        new_word(40'h4D4F4F5245);                   // MOORE
        do_guess(8'h50);                            // P: miss
        do_guess(8'h4D);                            // M: 10000
        do_guess(8'h4F);                            // O: 11100
        do_guess(8'h4F);                            // repeat O: no-op
        do_guess(8'h31);                            // dropped
        do_guess(8'h52);
        do_guess(8'h45);                            // win
        do_guess(8'h41);                            // ignored in WIN
        chk("win_hold.win", {7'd0, win}, 8'd1);

        // Lose: repeats still count, non-letter dropped
        new_word(40'h4D4F4F5245);
        do_guess(8'h50);
        do_guess(8'h5A);
        do_guess(8'h50);
        do_guess(8'h31);
        do_guess(8'h41);
        do_guess(8'h42);
        do_guess(8'h4D);
        do_guess(8'h43);                            // sixth miss
        do_guess(8'h4F);                            // ignored in LOSE
        chk("lose_hold.incorrect", {5'd0, incorrect}, 8'd6);

        // word_valid aborts a guess mid-scan
        new_word(40'h4D4F4F5245);
        letter = 8'h4D; letter_valid = 1'b1;
        tick();
        letter_valid = 1'b0;
        tick();
        new_word(40'h4141414141);
        do_guess(8'h41);                            // AAAAA: win in one guess

        // rst at E3 of a guess
        new_word(40'h4D4F4F5245);
        do_guess(8'h4D);
        letter = 8'h4F; letter_valid = 1'b1;
        tick();
        letter_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_started = 1'b0;
        m_clear();
        check_all("rst_mid_scan");
        do_guess(8'h4F);                            // ignored in IDLE

        // Random games
        for (int g = 0; g < 8; g++) begin
            for (int i = 0; i < 5; i++) w[39-8*i -: 8] = 8'($urandom_range(65, 90));
            new_word(w);
            for (int k = 0; k < 20 && !m_over(); k++) begin
                r = int'($urandom_range(0, 9));
                if (r < 5)      l = m_word[$urandom_range(0, 4)];
                else if (r < 9) l = 8'($urandom_range(65, 90));
                else            l = 8'($urandom_range(0, 64));
                do_guess(l);
            end
            do_guess(8'($urandom_range(65, 90)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
